// File: rtl/mix_columns_seq_pkg.sv
// Shared types, FSM encoding and GF(2^8) helpers for the sequential MixColumns block.
// INV_MIX_COLUMNS_EN (see mix_columns_seq.sv) adds the inverse transform.
package mix_columns_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    localparam logic [7:0] GF_REDUCE = 8'h1B;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  column_t;
    typedef logic [127:0] aes_state_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

    // Column c lives in bits [127-32c -: 32]; byte 0 is the MSB.
    function automatic column_t get_column(input aes_state_t s, input logic [1:0] idx);
        case (idx)
            2'd0:    return s[127:96];
            2'd1:    return s[95:64];
            2'd2:    return s[63:32];
            default: return s[31:0];
        endcase
    endfunction

    function automatic aes_state_t set_column(input aes_state_t s, input logic [1:0] idx,
                                              input column_t c);
        aes_state_t r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_columns_seq_mix_column.sv
// Combinational MixColumns on one 32-bit column (row 0 in the MSB byte).
// With INV_MIX_COLUMNS_EN, i_inv selects the inverse coefficients 0e/0b/0d/09.
module mix_column
    import mix_columns_seq_pkg::*;
(
`ifdef INV_MIX_COLUMNS_EN
    input  logic    i_inv,
`endif
    input  column_t i_col,
    output column_t o_col
);

    function automatic byte_t fwd_row(input byte_t a, input byte_t b, input byte_t c, input byte_t d);
        return xtime(a) ^ xtime(b) ^ b ^ c ^ d;
    endfunction

`ifdef INV_MIX_COLUMNS_EN
    function automatic byte_t inv_row(input byte_t a, input byte_t b, input byte_t c, input byte_t d);
        byte_t a2, a4, a8, b2, b8, c4, c8, d8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        b2 = xtime(b);
        b8 = xtime(xtime(b2));
        c4 = xtime(xtime(c));
        c8 = xtime(c4);
        d8 = xtime(xtime(xtime(d)));
        return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
    endfunction
`endif

    byte_t   w_s0, w_s1, w_s2, w_s3;
    column_t w_fwd;

    assign w_s0  = i_col[31:24];
    assign w_s1  = i_col[23:16];
    assign w_s2  = i_col[15:8];
    assign w_s3  = i_col[7:0];
    assign w_fwd = {fwd_row(w_s0, w_s1, w_s2, w_s3), fwd_row(w_s1, w_s2, w_s3, w_s0),
                    fwd_row(w_s2, w_s3, w_s0, w_s1), fwd_row(w_s3, w_s0, w_s1, w_s2)};

    // Direction select
    always_comb begin
        o_col = w_fwd;
`ifdef INV_MIX_COLUMNS_EN
        if (i_inv) begin
            o_col = {inv_row(w_s0, w_s1, w_s2, w_s3), inv_row(w_s1, w_s2, w_s3, w_s0),
                     inv_row(w_s2, w_s3, w_s0, w_s1), inv_row(w_s3, w_s0, w_s1, w_s2)};
        end else begin
            o_col = w_fwd;
        end
`endif
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: COLS_PER_CYCLE columns per BUSY cycle, valid/ready on both sides.
// Define INV_MIX_COLUMNS_EN to add the 'inv' port and the inverse transform.
module mix_columns_seq
    import mix_columns_seq_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef INV_MIX_COLUMNS_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    // STEP wraps to 0 for four columns per cycle, which is col+4 mod 4.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    fsm_state_e r_state, w_state_nxt;
    logic [1:0] r_col, w_col_nxt;
    aes_state_t r_data, w_data_nxt, w_mixed;
`ifdef INV_MIX_COLUMNS_EN
    logic       r_inv, w_inv_nxt;
`endif

    column_t w_col_in  [COLS_PER_CYCLE];
    column_t w_col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
        localparam logic [1:0] OFFSET = 2'(g);
        assign w_col_in[g] = get_column(r_data, r_col + OFFSET);
        mix_column u_mix_column (
`ifdef INV_MIX_COLUMNS_EN
            .i_inv (r_inv),
`endif
            .i_col (w_col_in[g]),
            .o_col (w_col_out[g])
        );
    end

    // Write the transformed column group back into a copy of the working state
    always_comb begin
        w_mixed = r_data;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            w_mixed = set_column(w_mixed, r_col + 2'(g), w_col_out[g]);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_data_nxt  = r_data;
`ifdef INV_MIX_COLUMNS_EN
        w_inv_nxt   = r_inv;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = BUSY;
                    w_col_nxt   = 2'd0;
                    w_data_nxt  = in_data;
`ifdef INV_MIX_COLUMNS_EN
                    w_inv_nxt   = inv;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                w_data_nxt = w_mixed;
                w_col_nxt  = r_col + STEP;
                if (r_col == LAST_COL) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, column counter and working register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= 2'd0;
            r_data  <= 128'd0;
`ifdef INV_MIX_COLUMNS_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_data  <= w_data_nxt;
`ifdef INV_MIX_COLUMNS_EN
            r_inv   <= w_inv_nxt;
`endif
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_data;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq with COLS_PER_CYCLE = 1, 2 and 4 side by side.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
`ifdef INV_MIX_COLUMNS_EN
    logic         inv;
`endif
    logic         or1, or2, or4;
    logic         ir1, ir2, ir4;
    logic         ov1, ov2, ov4;
    logic [127:0] od1, od2, od4;

    int n_cmp  = 0;
    int n_fail = 0;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
`ifdef INV_MIX_COLUMNS_EN
        .inv(inv),
`endif
        .out_valid(ov1), .out_ready(or1), .out_data(od1));

    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
`ifdef INV_MIX_COLUMNS_EN
        .inv(inv),
`endif
        .out_valid(ov2), .out_ready(or2), .out_data(od2));

    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
`ifdef INV_MIX_COLUMNS_EN
        .inv(inv),
`endif
        .out_valid(ov4), .out_ready(or4), .out_data(od4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference forward MixColumns over the whole state
    function automatic logic [127:0] mc_ref(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4]
                                           ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return o;
    endfunction

    // One transaction into all three DUTs with 14 cycles of backpressure and junk inputs
    task automatic run_txn(input string tag, input logic [127:0] d, input logic [127:0] exp);
        int lat1, lat2, lat4;
        lat1 = 0; lat2 = 0; lat4 = 0;
        in_data = d; in_valid = 1'b1; or1 = 1'b0; or2 = 1'b0; or4 = 1'b0;
        tick();
        for (int c = 1; c <= 14; c++) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            if (ov1 && lat1 == 0) lat1 = c;
            if (ov2 && lat2 == 0) lat2 = c;
            if (ov4 && lat4 == 0) lat4 = c;
        end
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 128'(lat1), 128'd4);
        chk({tag, "_lat2"}, 128'(lat2), 128'd2);
        chk({tag, "_lat4"}, 128'(lat4), 128'd1);
        chk({tag, "_hold_ready"}, {ir1, ir2, ir4}, 3'b000);
        chk({tag, "_hold_valid"}, {ov1, ov2, ov4}, 3'b111);
        chk({tag, "_data1"}, od1, exp);
        chk({tag, "_data2"}, od2, exp);
        chk({tag, "_data4"}, od4, exp);
        or1 = 1'b1; or2 = 1'b1; or4 = 1'b1;
        tick();
        chk({tag, "_drain_ready"}, {ir1, ir2, ir4}, 3'b111);
        chk({tag, "_drain_valid"}, {ov1, ov2, ov4}, 3'b000);
        or1 = 1'b0; or2 = 1'b0; or4 = 1'b0;
    endtask

    initial begin
        logic [127:0] q1 [$];
        logic [127:0] q2 [$];
        logic [127:0] q4 [$];
        int acc1, acc2, acc4, res1, res2, res4, seen;

        rst = 1'b0; in_valid = 1'b0; in_data = 128'd0;
        or1 = 1'b0; or2 = 1'b0; or4 = 1'b0;
`ifdef INV_MIX_COLUMNS_EN
        inv = 1'b0;
`endif
        #2 rst = 1'b1;
        #2;
        chk("rst_in_ready", {ir1, ir2, ir4}, 3'b111);
        chk("rst_out_valid", {ov1, ov2, ov4}, 3'b000);
        chk("rst_out_data", od1 | od2 | od4, 128'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_txn("col_db", {4{32'hdb135345}}, {4{32'h8e4da1bc}});
        run_txn("fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h046681e5e0cb199a48f8d37a2806264c);
        run_txn("mixed", {32'hf20a225c, 32'h01010101, 32'hd4d4d4d5, 32'h2d26314c},
                         {32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6, 32'h4d7ebdf8});

        // Reset in the middle of an operation
        in_data = {16{8'h5a}}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", {ir1, ir2, ir4}, 3'b111);
        chk("midrst_out_valid", {ov1, ov2, ov4}, 3'b000);
        chk("midrst_out_data", od1 | od2 | od4, 128'd0);
        #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ov1 || ov2 || ov4) seen++;
        end
        chk("midrst_no_valid", 128'(seen), 128'd0);
        run_txn("all_c6", {16{8'hc6}}, {16{8'hc6}});

`ifdef INV_MIX_COLUMNS_EN
        inv = 1'b1;
        run_txn("inv_col", {32'h8e4da1bc, 32'h01010101, 32'h8e4da1bc, 32'h01010101},
                           {32'hdb135345, 32'h01010101, 32'hdb135345, 32'h01010101});
        run_txn("inv_fips", 128'h046681e5e0cb199a48f8d37a2806264c, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        inv = 1'b0;
`endif

        // Back-to-back streaming with both handshakes held high
        acc1 = 0; acc2 = 0; acc4 = 0; res1 = 0; res2 = 0; res4 = 0;
        in_valid = 1'b1; or1 = 1'b1; or2 = 1'b1; or4 = 1'b1;
        for (int c = 0; c < 36; c++) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (ir1) begin acc1++; q1.push_back(in_data); end
            if (ir2) begin acc2++; q2.push_back(in_data); end
            if (ir4) begin acc4++; q4.push_back(in_data); end
            if (ov1) begin res1++; chk("b2b_data1", od1, (q1.size() > 0) ? mc_ref(q1.pop_front()) : 128'hx); end
            if (ov2) begin res2++; chk("b2b_data2", od2, (q2.size() > 0) ? mc_ref(q2.pop_front()) : 128'hx); end
            if (ov4) begin res4++; chk("b2b_data4", od4, (q4.size() > 0) ? mc_ref(q4.pop_front()) : 128'hx); end
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_acc1", 128'(acc1), 128'd6);
        chk("b2b_acc2", 128'(acc2), 128'd9);
        chk("b2b_acc4", 128'(acc4), 128'd12);
        chk("b2b_res1", 128'(res1), 128'd6);
        chk("b2b_res2", 128'(res2), 128'd9);
        chk("b2b_res4", 128'(res4), 128'd12);
        chk("b2b_idle", {ir1, ir2, ir4}, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, giving the number of state columns transformed per BUSY cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept in_data.
REQ-006 SHALL have port in_data, input, 128 bits: AES state; [127:120] is byte 0, column c is bytes 4c..4c+3, row r is byte 4c+r.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-009 SHALL have port out_data, output, 128 bits: transformed state, same byte order as in_data.

Function
REQ-010 SHALL be an FSM with states IDLE, BUSY and DONE, plus a column counter col of width 2.
REQ-011 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE; neither depends combinationally on in_valid or out_ready.
REQ-012 On in_valid & in_ready in IDLE: capture in_data into the working register, set col = 0, go to BUSY.
REQ-013 In BUSY, each cycle: replace columns col .. col+COLS_PER_CYCLE-1 with their MixColumns result, then advance col by COLS_PER_CYCLE (mod 4).
REQ-014 The forward column transform SHALL be o_r = 02*s_r ^ 03*s_(r+1) ^ s_(r+2) ^ s_(r+3), row indices mod 4.
REQ-015 Multiplication SHALL be in GF(2^8) mod 0x11B, where xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0) and 03*x = xtime(x) ^ x.
REQ-016 When the last column group is written, the FSM SHALL enter DONE, giving out_valid exactly 4/COLS_PER_CYCLE cycles after the accept edge.
REQ-017 out_data SHALL be the working register and SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-018 On out_valid & out_ready, the FSM SHALL go to IDLE; a new input can be accepted at the earliest one cycle later (no same-cycle accept).
REQ-019 in_data and in_valid SHALL be ignored in BUSY and DONE.

Reset
REQ-020 While rst = 1, asynchronously: state = IDLE, col = 0, working register = 0.
REQ-021 While rst = 1: out_valid = 0, out_data = 0, in_ready = 1.
REQ-022 Reset asserted in BUSY or DONE SHALL discard the operation in progress; no partial result SHALL ever be presented.

Configuration
REQ-023 Macro INV_MIX_COLUMNS_EN defined: the block SHALL add input port inv, 1 bit, sampled at the accept edge and held for the whole operation.
REQ-024 With INV_MIX_COLUMNS_EN and inv = 1: the column transform SHALL use coefficients 0e, 0b, 0d, 09 in place of 02, 03, 01, 01.
REQ-025 Macro INV_MIX_COLUMNS_EN undefined: the inv port and all inverse logic SHALL be absent, and the block SHALL be forward-only.

Structure
REQ-026 The shared package SHALL hold the FSM state enum, the constant 8'h1B, and the byte, column and state typedefs.
REQ-027 SHALL instantiate COLS_PER_CYCLE copies of a sub-module mix_column: combinational, 32-bit in/out, plus inv when INV_MIX_COLUMNS_EN is defined, built on xtime.

Verification
REQ-028 Column db,13,53,45 placed in all four columns, COLS_PER_CYCLE = 1 -> every output column is 8e,4d,a1,bc; out_valid rises exactly 4 cycles after the accept edge.
REQ-029 in_data d4bf5d30e0b452aeb84111f11e2798e5 -> out_data 046681e5e0cb199a48f8d37a2806264c, for each of COLS_PER_CYCLE = 1, 2, 4 (latency 4, 2, 1).
REQ-030 out_ready held 0 for 10 cycles after out_valid -> out_data stable, in_ready = 0, and a changing in_data is ignored.
REQ-031 rst pulsed during the 2nd BUSY cycle -> out_valid never asserts; the next transaction with all bytes c6 -> result all c6.
REQ-032 INV_MIX_COLUMNS_EN defined, inv = 1, column 8e,4d,a1,bc -> db,13,53,45; column 01,01,01,01 -> 01,01,01,01.
REQ-033 Back-to-back transactions with in_valid and out_ready held high -> exactly one accept per (4/COLS_PER_CYCLE)+2 cycles, with no lost or duplicated results.
